// File: rtl/btn_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner: FSM state encoding,
// button indices and the counter sizing helper.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REPEAT,
    RELEASE_CHK
  } btn_state_t;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  // One counter width serves all three timing phases, so size it for the longest.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Raw key levels in, conditioned move pulses out; the conditioner uses the slave side.
interface btn_conditioner_if;
  logic Key_Up;
  logic Key_Down;
  logic Key_Left;
  logic Key_Right;
  logic Btn_Up;
  logic Btn_Down;
  logic Btn_Left;
  logic Btn_Right;

  modport master (
    output Key_Up, Key_Down, Key_Left, Key_Right,
    input  Btn_Up, Btn_Down, Btn_Left, Btn_Right
  );

  modport slave (
    input  Key_Up, Key_Down, Key_Left, Key_Right,
    output Btn_Up, Btn_Down, Btn_Left, Btn_Right
  );
endinterface

// File: rtl/btn_conditioner_debouncer.sv
// One button: 2-flop synchroniser, debounce/auto-repeat FSM and its counter.
// req is a combinational one-cycle request; the top registers it into Btn_*.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 500000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 10000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic p,
  output logic req
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam bit REPEAT_EN = (REPEAT_DELAY_CYCLES != 0);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = REPEAT_EN ? CNT_W'(REPEAT_DELAY_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_p0;
  logic             sync_p1;
  logic             s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Synchroniser stage: reset to the released level so a held key is seen as a new press.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= p;
      sync_p1 <= sync_p0;
    end
  end

  assign s = sync_p1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (s) state <= PRESS_CHK;
        end
        PRESS_CHK: begin
          if (!s) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!s) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end else if (REPEAT_EN && cnt == DLY_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!s) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end else if (cnt == RATE_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RELEASE_CHK: begin
          // A bounce back to pressed resumes the hold without issuing a new move.
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    req = 1'b0;
    case (state)
      PRESS_CHK: req = s && (cnt == DEB_LAST);
      HELD:      req = s && REPEAT_EN && (cnt == DLY_LAST);
      REPEAT:    req = s && (cnt == RATE_LAST);
      default:   req = 1'b0;
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Four-button front end: polarity fix-up, per-button debounce/repeat, and a
// fixed-priority registered output that emits at most one move pulse per cycle.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 500000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 10000000,
  parameter int ACTIVE_LOW          = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  btn_conditioner_if.slave   bus
);

  localparam logic POL = (ACTIVE_LOW != 0);

  logic [NUM_BTNS-1:0] key_raw;
  logic [NUM_BTNS-1:0] p;
  logic [NUM_BTNS-1:0] req;
  logic [NUM_BTNS-1:0] btn_p0;

  // Lowest index wins: Up > Down > Left > Right; losers are dropped.
  function automatic logic [NUM_BTNS-1:0] pick_one(input logic [NUM_BTNS-1:0] r);
    return r & (~r + NUM_BTNS'(1));
  endfunction

  assign key_raw[BTN_UP]    = bus.Key_Up;
  assign key_raw[BTN_DOWN]  = bus.Key_Down;
  assign key_raw[BTN_LEFT]  = bus.Key_Left;
  assign key_raw[BTN_RIGHT] = bus.Key_Right;

  assign p = key_raw ^ {NUM_BTNS{POL}};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debouncer #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
    ) u_deb (
      .Clk (Clk),
      .Rst (Rst),
      .p   (p[i]),
      .req (req[i])
    );
  end

  // Output register stage.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) btn_p0 <= '0;
    else     btn_p0 <= pick_one(req);
  end

  assign bus.Btn_Up    = btn_p0[BTN_UP];
  assign bus.Btn_Down  = btn_p0[BTN_DOWN];
  assign bus.Btn_Left  = btn_p0[BTN_LEFT];
  assign bus.Btn_Right = btn_p0[BTN_RIGHT];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timings.
// Button vectors are {Right, Left, Down, Up}; "e" is the edge that first samples the key.
module tb_btn_conditioner;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] btn_vec;

  btn_conditioner_if bus ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (20),
    .REPEAT_RATE_CYCLES  (8),
    .ACTIVE_LOW          (1)
  ) u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  assign btn_vec = {bus.Btn_Right, bus.Btn_Left, bus.Btn_Down, bus.Btn_Up};

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  // press bits are active-high; keys are driven active-low.
  task automatic drive(input logic [3:0] press);
    bus.Key_Up    = ~press[0];
    bus.Key_Down  = ~press[1];
    bus.Key_Left  = ~press[2];
    bus.Key_Right = ~press[3];
  endtask

  task automatic step(input logic [3:0] press, input logic [3:0] exp, input string tag, input int e);
    drive(press);
    @(posedge Clk);
    #1;
    chk($sformatf("%s e%0d", tag, e), btn_vec, exp);
  endtask

  initial begin
    drive(4'b0000);
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset", btn_vec, 4'b0000);
    Rst = 1'b0;

    // Single press held 15 cycles: one pulse after edge 6.
    for (int e = 0; e < 25; e++)
      step((e < 15) ? 4'b0001 : 4'b0000, (e == 6) ? 4'b0001 : 4'b0000, "s1_up", e);

    // Left bounces 1,0,1,0 then settles pressed from edge 4: pulse after edge 10.
    for (int e = 0; e < 30; e++)
      step(((e == 0 || e == 2 || e >= 4) && e < 20) ? 4'b0100 : 4'b0000,
           (e == 10) ? 4'b0100 : 4'b0000, "s2_left", e);

    // Down pressed for only 3 cycles: rejected.
    for (int e = 0; e < 15; e++)
      step((e < 3) ? 4'b0010 : 4'b0000, 4'b0000, "s3_down", e);

    // Right held 60 cycles: first pulse, delayed repeat, then fixed-rate repeats.
    for (int e = 0; e < 72; e++)
      step((e < 60) ? 4'b1000 : 4'b0000,
           (e == 6 || (e >= 26 && e < 60 && ((e - 26) % 8) == 0)) ? 4'b1000 : 4'b0000,
           "s4_right", e);

    // Up and Left together: Up wins every time, Left is dropped.
    for (int e = 0; e < 40; e++)
      step((e < 30) ? 4'b0101 : 4'b0000, (e == 6 || e == 26) ? 4'b0001 : 4'b0000, "s5_upleft", e);

    // Reset clears a live pulse without waiting for a clock edge.
    for (int e = 0; e < 7; e++)
      step(4'b0001, (e == 6) ? 4'b0001 : 4'b0000, "s6a_up", e);
    Rst = 1'b1;
    #1;
    chk("s6a_async_rst", btn_vec, 4'b0000);
    drive(4'b0000);
    repeat (2) @(posedge Clk);
    #1;
    chk("s6a_in_rst", btn_vec, 4'b0000);
    Rst = 1'b0;

    // Reset mid-debounce with Down still held: the press restarts from scratch.
    for (int e = 0; e < 4; e++)
      step(4'b0010, 4'b0000, "s6b_pre", e);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("s6b_in_rst", btn_vec, 4'b0000);
    Rst = 1'b0;
    for (int e = 0; e < 20; e++)
      step(4'b0010, (e == 6) ? 4'b0010 : 4'b0000, "s6b_post", e);
    for (int e = 20; e < 30; e++)
      step(4'b0000, 4'b0000, "s6b_rel", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
